// File: rtl/multicycle_controller.sv
// Main control unit of the multicycle RV32I core: Moore FSM, ALU decoder and immediate-type decoder.
// Optional feature macro: BRANCH_EXT_EN (adds bne, taken on ~Zero, sharing the BEQ state).
module multicycle_controller #(
  parameter int FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalInstr
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [3:0] FW     = 4'(FETCH_WAIT);

  state_t     state_q, state_d, cur;
  logic [3:0] cnt_q, cnt_d;

  logic       adr_src, mem_write, ir_write, reg_write;
  logic       pc_update, branch, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       branch_ok, take;
  logic [2:0] alu_ctl;
  logic [1:0] imm_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BRANCH_EXT_EN
  assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign take      = funct3[0] ? ~Zero : Zero;
`else
  assign branch_ok = (funct3 == 3'b000);
  assign take      = Zero;
`endif

  // While reset is high the outputs decode as FETCH; enables are masked below.
  always_comb begin
    cur        = reset ? S_FETCH : state_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (cnt_q == FW) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          cnt_d     = 4'd0;
          state_d   = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BR: begin
            if (branch_ok) begin
              state_d = S_BEQ;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_ctl = 3'b000;
    case (alu_op)
      2'b00: alu_ctl = 3'b000;
      2'b01: alu_ctl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_ctl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctl = 3'b101;
          3'b110:  alu_ctl = 3'b011;
          3'b111:  alu_ctl = 3'b010;
          default: alu_ctl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign PCWrite      = ~reset & (pc_update | (branch & take));
  assign IRWrite      = ~reset & ir_write;
  assign MemWrite     = ~reset & mem_write;
  assign RegWrite     = ~reset & reg_write;
  assign IllegalInstr = ~reset & illegal;
  assign AdrSrc       = adr_src;
  assign ResultSrc    = result_src;
  assign ALUSrcA      = alu_src_a;
  assign ALUSrcB      = alu_src_b;
  assign ALUControl   = alu_ctl;
  assign ImmSrc       = imm_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences, per-cycle expected output vectors
// in a queue, popped and compared by an independent monitor on the falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       sel;

  logic       pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, asa0, asb0, imm0;
  logic [2:0] alu0;
  logic       pcw2, adr2, mw2, irw2, rw2, ill2;
  logic [1:0] rs2, asa2, asb2, imm2;
  logic [2:0] alu2;

  logic [16:0] v0, v2;
  logic [16:0] exp_q[$];
  string       name_q[$];
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.FETCH_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(rs0),
    .ALUSrcA(asa0), .ALUSrcB(asb0), .ALUControl(alu0), .ImmSrc(imm0), .RegWrite(rw0),
    .IllegalInstr(ill0)
  );

  multicycle_controller #(.FETCH_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .ResultSrc(rs2),
    .ALUSrcA(asa2), .ALUSrcB(asb2), .ALUControl(alu2), .ImmSrc(imm2), .RegWrite(rw2),
    .IllegalInstr(ill2)
  );

  // Vector layout: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc RegWrite IllegalInstr
  assign v0 = {pcw0, adr0, mw0, irw0, rs0, asa0, asb0, alu0, imm0, rw0, ill0};
  assign v2 = {pcw2, adr2, mw2, irw2, rs2, asa2, asb2, alu2, imm2, rw2, ill2};

  function automatic logic [16:0] vec(input logic pcw, adr, mw, irw, input logic [1:0] rs, asa, asb,
                                      input logic [2:0] alu, input logic [1:0] imm, input logic rw, ill);
    return {pcw, adr, mw, irw, rs, asa, asb, alu, imm, rw, ill};
  endfunction

  always @(negedge clk) begin
    logic [16:0] e, a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sel ? v2 : v0;
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL %s: got %b expected %b", n, a, e);
      end
    end
  end

  task automatic cyc(input string n, input logic [16:0] v);
    exp_q.push_back(v);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic do_fetch(input string n, input logic [1:0] imm);
    cyc({n, "_fetch"}, vec(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0));
  endtask

  task automatic do_decode(input string n, input logic [1:0] imm, input logic ill);
    cyc({n, "_decode"}, vec(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, ill));
  endtask

  task automatic do_aluwb(input string n, input logic [1:0] imm);
    cyc({n, "_aluwb"}, vec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0));
  endtask

  task automatic do_rtype(input string n, input logic [2:0] f3, input logic f7, input logic [2:0] exp_alu);
    set_in(7'b0110011, f3, f7, 1'b0);
    do_fetch(n, 2'b00);
    do_decode(n, 2'b00, 1'b0);
    cyc({n, "_exec"}, vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, exp_alu, 2'b00, 0, 0));
    do_aluwb(n, 2'b00);
  endtask

  task automatic do_itype(input string n, input logic [2:0] f3, input logic f7, input logic [2:0] exp_alu);
    set_in(7'b0010011, f3, f7, 1'b0);
    do_fetch(n, 2'b00);
    do_decode(n, 2'b00, 1'b0);
    cyc({n, "_exec"}, vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, exp_alu, 2'b00, 0, 0));
    do_aluwb(n, 2'b00);
  endtask

  task automatic do_branch(input string n, input logic [2:0] f3, input logic z, input logic exp_pcw);
    set_in(7'b1100011, f3, 1'b0, z);
    do_fetch(n, 2'b10);
    do_decode(n, 2'b10, 1'b0);
    cyc({n, "_beq"}, vec(exp_pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));
  endtask

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      cyc("reset_hold", vec(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
    reset = 1'b0;

    // lw: FETCH DECODE MEMADR MEMREAD MEMWB
    do_fetch("lw", 2'b00);
    do_decode("lw", 2'b00, 1'b0);
    cyc("lw_memadr", vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
    cyc("lw_memread", vec(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
    cyc("lw_memwb", vec(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));

    set_in(7'b0100011, 3'b010, 1'b0, 1'b1);
    do_fetch("sw", 2'b01);
    do_decode("sw", 2'b01, 1'b0);
    cyc("sw_memadr", vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
    cyc("sw_memwrite", vec(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));

    do_rtype("r_sub", 3'b000, 1'b1, 3'b001);
    do_rtype("r_add", 3'b000, 1'b0, 3'b000);
    do_rtype("r_and", 3'b111, 1'b0, 3'b010);
    do_rtype("r_or",  3'b110, 1'b0, 3'b011);
    do_rtype("r_slt", 3'b010, 1'b0, 3'b101);
    do_rtype("r_xor_dflt", 3'b100, 1'b1, 3'b000);
    do_itype("i_addi_f7", 3'b000, 1'b1, 3'b000);
    do_itype("i_ori", 3'b110, 1'b0, 3'b011);

    do_branch("beq_taken", 3'b000, 1'b1, 1'b1);
    do_branch("beq_not", 3'b000, 1'b0, 1'b0);

    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    do_fetch("jal", 2'b11);
    do_decode("jal", 2'b11, 1'b0);
    cyc("jal_jal", vec(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0));
    do_aluwb("jal", 2'b11);

    set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
    do_fetch("illegal_op", 2'b00);
    do_decode("illegal_op", 2'b00, 1'b1);

`ifdef BRANCH_EXT_EN
    do_branch("bne_taken", 3'b001, 1'b0, 1'b1);
    do_branch("bne_not", 3'b001, 1'b1, 1'b0);
`else
    set_in(7'b1100011, 3'b001, 1'b0, 1'b0);
    do_fetch("bne_illegal", 2'b10);
    do_decode("bne_illegal", 2'b10, 1'b1);
`endif
    set_in(7'b1100011, 3'b010, 1'b0, 1'b0);
    do_fetch("br_f3_010", 2'b10);
    do_decode("br_f3_010", 2'b10, 1'b1);

    // sw aborted by reset in MEMWRITE, then a complete sw
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    do_fetch("sw_abort", 2'b01);
    do_decode("sw_abort", 2'b01, 1'b0);
    cyc("sw_abort_memadr", vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
    reset = 1'b1;
    cyc("sw_abort_rst", vec(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0, 0));
    reset = 1'b0;
    do_fetch("sw_after", 2'b01);
    do_decode("sw_after", 2'b01, 1'b0);
    cyc("sw_after_memadr", vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
    cyc("sw_after_memwrite", vec(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));

    // FETCH_WAIT=2 instance: FETCH spans three cycles
    sel = 1'b1;
    reset = 1'b1;
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    cyc("fw2_reset", vec(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc("fw2_lw_wait", vec(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
    end
    do_fetch("fw2_lw", 2'b00);
    do_decode("fw2_lw", 2'b00, 1'b0);
    cyc("fw2_lw_memadr", vec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
    cyc("fw2_lw_memread", vec(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
    cyc("fw2_lw_memwb", vec(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
    set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc("fw2_beq_wait", vec(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0));
    end
    do_fetch("fw2_beq", 2'b10);
    do_decode("fw2_beq", 2'b10, 1'b0);
    cyc("fw2_beq_beq", vec(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 0));

    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
